// File: rtl/alu_seq_param.sv
// alu_seq_param
//   Parametrised, handshaked 16-opcode ALU placed between the operand
//   register file and the writeback stage. Most opcodes complete in one cycle.
//   MUL (shift-add) and non-zero DIV (restoring) are iterative. They retire
//   one bit per clock, so the result appears exactly WIDTH edges after accept.
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready accept handshake; an op is taken on in_valid && in_ready
//   A, B, ALU_FUN     operands (B also carries the shift amount) and opcode
//   ALU_OUT           registered result, held until the next result
//   out_valid         one-cycle pulse marking a new ALU_OUT and new flags
//   *_flag            category flags (one-hot) plus carry/borrow and div-by-zero
//   busy              an iterative op is in progress (inverse of in_ready)
module alu_seq_param #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             out_valid,
  output logic             Arith_flag,
  output logic             Logic_flag,
  output logic             CMP_flag,
  output logic             Shift_flag,
  output logic             Carry_flag,
  output logic             Div0_flag,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_MUL = 4'h2, OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4, OP_OR   = 4'h5, OP_NAND = 4'h6, OP_NOR = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8, OP_XNOR = 4'h9, OP_EQ  = 4'hA, OP_GT   = 4'hB;
  localparam logic [3:0] OP_LT   = 4'hC, OP_SHR  = 4'hD, OP_SHL = 4'hE;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // acc: partial product (MUL) or partial remainder (DIV)
  // x:   shifting multiplicand (MUL) or dividend turning into quotient (DIV)
  // y:   shifting multiplier (MUL) or divisor (DIV)
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [WIDTH-1:0]   alu_out_q, alu_out_d;
  logic               out_valid_q, out_valid_d;
  logic               arith_q, arith_d, logic_q, logic_d, cmp_q, cmp_d;
  logic               shift_q, shift_d, carry_q, carry_d, div0_q, div0_d;

  logic [WIDTH:0]     add_sum;
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH:0]     div_shift, div_rem;
  logic               div_ge;

  assign add_sum = {1'b0, A} + {1'b0, B};
  assign shamt   = B[SHW-1:0];
  assign mul_acc = y_q[0] ? acc_q + x_q : acc_q;

  // Restoring step: bring the next dividend bit into the remainder and keep
  // the subtraction only if it does not go negative.
  assign div_shift = {acc_q[WIDTH-1:0], x_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, y_q};
  assign div_rem   = div_ge ? div_shift - {1'b0, y_q} : div_shift;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    x_d         = x_q;
    y_d         = y_q;
    alu_out_d   = alu_out_q;
    out_valid_d = 1'b0;
    arith_d     = arith_q;
    logic_d     = logic_q;
    cmp_d       = cmp_q;
    shift_d     = shift_q;
    carry_d     = carry_q;
    div0_d      = div0_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (ALU_FUN == OP_MUL) begin
            state_d = S_MUL;
            cnt_d   = CW'(WIDTH);
            acc_d   = '0;
            x_d     = {{WIDTH{1'b0}}, A};
            y_d     = B;
          end else if (ALU_FUN == OP_DIV && B != '0) begin
            state_d = S_DIV;
            cnt_d   = CW'(WIDTH);
            acc_d   = '0;
            x_d     = {{WIDTH{1'b0}}, A};
            y_d     = B;
          end else begin
            out_valid_d = 1'b1;
            alu_out_d   = '0;
            {arith_d, logic_d, cmp_d, shift_d, carry_d, div0_d} = 6'b000000;
            case (ALU_FUN)
              OP_ADD:  begin alu_out_d = add_sum[WIDTH-1:0]; carry_d = add_sum[WIDTH]; arith_d = 1'b1; end
              OP_SUB:  begin alu_out_d = A - B; carry_d = (A < B); arith_d = 1'b1; end
              // Only B==0 reaches here for DIV.
              OP_DIV:  begin alu_out_d = '1; div0_d = 1'b1; arith_d = 1'b1; end
              OP_AND:  begin alu_out_d = A & B;    logic_d = 1'b1; end
              OP_OR:   begin alu_out_d = A | B;    logic_d = 1'b1; end
              OP_NAND: begin alu_out_d = ~(A & B); logic_d = 1'b1; end
              OP_NOR:  begin alu_out_d = ~(A | B); logic_d = 1'b1; end
              OP_XOR:  begin alu_out_d = A ^ B;    logic_d = 1'b1; end
              OP_XNOR: begin alu_out_d = ~(A ^ B); logic_d = 1'b1; end
              OP_EQ:   begin alu_out_d[0] = (A == B); cmp_d = 1'b1; end
              OP_GT:   begin alu_out_d[0] = (A > B);  cmp_d = 1'b1; end
              OP_LT:   begin alu_out_d[0] = (A < B);  cmp_d = 1'b1; end
              OP_SHR:  begin alu_out_d = A >> shamt; shift_d = 1'b1; end
              OP_SHL:  begin alu_out_d = A << shamt; shift_d = 1'b1; end
              default: ; // NOP: zero result, no flags
            endcase
          end
        end
      end

      S_MUL: begin
        acc_d = mul_acc;
        x_d   = x_q << 1;
        y_d   = y_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          alu_out_d   = mul_acc[WIDTH-1:0];
          {arith_d, logic_d, cmp_d, shift_d, carry_d, div0_d} = 6'b100000;
          carry_d     = |mul_acc[2*WIDTH-1:WIDTH];
        end
      end

      S_DIV: begin
        acc_d = {{(WIDTH-1){1'b0}}, div_rem};
        x_d   = {{WIDTH{1'b0}}, x_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          alu_out_d   = {x_q[WIDTH-2:0], div_ge};
          {arith_d, logic_d, cmp_d, shift_d, carry_d, div0_d} = 6'b100000;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      alu_out_q   <= '0;
      out_valid_q <= 1'b0;
      arith_q     <= 1'b0;
      logic_q     <= 1'b0;
      cmp_q       <= 1'b0;
      shift_q     <= 1'b0;
      carry_q     <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      y_q         <= y_d;
      alu_out_q   <= alu_out_d;
      out_valid_q <= out_valid_d;
      arith_q     <= arith_d;
      logic_q     <= logic_d;
      cmp_q       <= cmp_d;
      shift_q     <= shift_d;
      carry_q     <= carry_d;
      div0_q      <= div0_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = ~in_ready;
  assign ALU_OUT    = alu_out_q;
  assign out_valid  = out_valid_q;
  assign Arith_flag = arith_q;
  assign Logic_flag = logic_q;
  assign CMP_flag   = cmp_q;
  assign Shift_flag = shift_q;
  assign Carry_flag = carry_q;
  assign Div0_flag  = div0_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// tb_alu_seq_param
//   Drives alu_seq_param (WIDTH=16) with directed scenarios and random traffic.
//   A reference model holds the expected registered outputs and checks them
//   every cycle. The model computes results with plain integer arithmetic and
//   tracks the iterative-op latency with a countdown.
module tb_alu_seq_param;

  localparam int W   = 16;
  localparam int SHW = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic [3:0]   fun = '0;
  logic [W-1:0] alu_out;
  logic         out_valid, arith_f, logic_f, cmp_f, shift_f, carry_f, div0_f, busy;

  alu_seq_param #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_i), .B(b_i), .ALU_FUN(fun), .ALU_OUT(alu_out), .out_valid(out_valid),
    .Arith_flag(arith_f), .Logic_flag(logic_f), .CMP_flag(cmp_f),
    .Shift_flag(shift_f), .Carry_flag(carry_f), .Div0_flag(div0_f), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] out;
    logic ar, lo, cm, sh, cy, d0;
  } res_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result of one operation, straight from the opcode table.
  function automatic res_t ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    longint unsigned la, lb, s;
    int sh;
    r  = '0;
    la = 64'(a);
    lb = 64'(b);
    sh = int'(b[SHW-1:0]);
    case (op)
      4'd0:  begin s = la + lb; r.out = W'(s); r.cy = (s >> W) != 0; end
      4'd1:  begin r.out = W'(la - lb); r.cy = (la < lb); end
      4'd2:  begin s = la * lb; r.out = W'(s); r.cy = (s >> W) != 0; end
      4'd3:  if (lb == 0) begin r.out = '1; r.d0 = 1'b1; end else r.out = W'(la / lb);
      4'd4:  r.out = a & b;
      4'd5:  r.out = a | b;
      4'd6:  r.out = ~(a & b);
      4'd7:  r.out = ~(a | b);
      4'd8:  r.out = a ^ b;
      4'd9:  r.out = ~(a ^ b);
      4'd10: r.out = (la == lb) ? W'(1) : W'(0);
      4'd11: r.out = (la > lb) ? W'(1) : W'(0);
      4'd12: r.out = (la < lb) ? W'(1) : W'(0);
      4'd13: r.out = a >> sh;
      4'd14: r.out = a << sh;
      default: ;
    endcase
    r.ar = (op <= 4'd3);
    r.lo = (op >= 4'd4) && (op <= 4'd9);
    r.cm = (op >= 4'd10) && (op <= 4'd12);
    r.sh = (op == 4'd13) || (op == 4'd14);
    return r;
  endfunction

  // Reference model state
  res_t held;
  res_t pending;
  res_t nr;
  logic exp_valid = 1'b0;
  int   busy_left = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      held      = '0;
      exp_valid = 1'b0;
      busy_left = 0;
    end else begin
      exp_valid = 1'b0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          held      = pending;
          exp_valid = 1'b1;
        end
      end else if (in_valid) begin
        nr = ref_op(fun, a_i, b_i);
        if (fun == 4'd2 || (fun == 4'd3 && b_i != '0)) begin
          pending   = nr;
          busy_left = W;
        end else begin
          held      = nr;
          exp_valid = 1'b1;
        end
      end
    end
    #1;
    chk("cycle {valid,ready,busy,out,ar,lo,cm,sh,cy,d0}",
        {out_valid, in_ready, busy, alu_out, arith_f, logic_f, cmp_f, shift_f, carry_f, div0_f},
        {exp_valid, busy_left == 0, busy_left != 0, held});
    if (exp_valid)
      $display("txn result out=%04h flags ar=%0b lo=%0b cm=%0b sh=%0b cy=%0b d0=%0b",
               held.out, held.ar, held.lo, held.cm, held.sh, held.cy, held.d0);
  end

  // One directed op from an idle DUT; waits (bounded) for the result pulse.
  task automatic do_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eout, input logic ecy,
                       input logic ed0, input logic [3:0] ecat, input int elat);
    int   cyc;
    int   low;
    logic got;
    @(negedge clk);
    fun = op; a_i = a; b_i = b; in_valid = 1'b1;
    cyc = 0; low = 0; got = 1'b0;
    while (!got && cyc < W + 4) begin
      @(negedge clk);
      in_valid = 1'b0;
      cyc++;
      if (out_valid === 1'b1) got = 1'b1;
      else if (in_ready === 1'b0) low++;
    end
    chk({name, " out_valid seen"}, 64'(got), 64'(1));
    chk({name, " latency"}, 64'(cyc), 64'(elat));
    chk({name, " in_ready low cycles"}, 64'(low), 64'(elat - 1));
    chk({name, " ALU_OUT"}, 64'(alu_out), 64'(eout));
    chk({name, " carry/div0"}, {carry_f, div0_f}, {ecy, ed0});
    chk({name, " category"}, {arith_f, logic_f, cmp_f, shift_f}, 64'(ecat));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t p;
    int   pulses;
    logic [W-1:0] last;

    // Pin the reference model to hand-computed values.
    p = ref_op(4'd0, 16'hFFFF, 16'd1);  chk("model ADD wrap", {p.out, p.cy}, {16'h0000, 1'b1});
    p = ref_op(4'd2, 16'd300, 16'd300); chk("model MUL 300*300", {p.out, p.cy}, {16'h5F90, 1'b1});
    p = ref_op(4'd3, 16'd100, 16'd7);   chk("model DIV 100/7", {p.out, p.d0}, {16'd14, 1'b0});
    p = ref_op(4'd13, 16'h8000, 16'd20); chk("model SHR by 20", 64'(p.out), 64'h0800);
    p = ref_op(4'd1, 16'd3, 16'd6);     chk("model SUB 3-6", {p.out, p.cy}, {16'hFFFD, 1'b1});

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Scenarios 1-3
    do_op("ADD FFFF+1", 4'd0, 16'hFFFF, 16'd1, 16'h0000, 1'b1, 1'b0, 4'b1000, 1);
    do_op("MUL 300*300", 4'd2, 16'd300, 16'd300, 16'h5F90, 1'b1, 1'b0, 4'b1000, W + 1);
    do_op("MUL 6*3", 4'd2, 16'd6, 16'd3, 16'd18, 1'b0, 1'b0, 4'b1000, W + 1);
    do_op("DIV 100/7", 4'd3, 16'd100, 16'd7, 16'd14, 1'b0, 1'b0, 4'b1000, W + 1);
    do_op("DIV by 0", 4'd3, 16'd55, 16'd0, 16'hFFFF, 1'b0, 1'b1, 4'b1000, 1);

    // Scenario 4: back-to-back single-cycle ops
    @(negedge clk); fun = 4'd0; a_i = 16'd6; b_i = 16'd3; in_valid = 1'b1;
    @(negedge clk); fun = 4'd8;
    chk("b2b first pulse {valid,out}", {out_valid, alu_out}, {1'b1, 16'd9});
    @(negedge clk); in_valid = 1'b0;
    chk("b2b second pulse {valid,out}", {out_valid, alu_out}, {1'b1, 16'd5});
    @(negedge clk);
    chk("b2b pulse ends", 64'(out_valid), 64'(0));

    // Scenario 4b: in_valid pulsed during DIV is ignored
    @(negedge clk); fun = 4'd3; a_i = 16'd100; b_i = 16'd7; in_valid = 1'b1;
    pulses = 0; last = '0;
    for (int i = 1; i <= W + 6; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin pulses++; last = alu_out; end
      if (i == 1) in_valid = 1'b0;
      if (i == 6) begin fun = 4'd0; a_i = 16'd1; b_i = 16'd1; in_valid = 1'b1; end
      if (i == 7) in_valid = 1'b0;
    end
    chk("mid-DIV pulse count", 64'(pulses), 64'(1));
    chk("mid-DIV quotient", 64'(last), 64'(14));

    // Scenario 5: reset during MUL
    @(negedge clk); fun = 4'd2; a_i = 16'd300; b_i = 16'd300; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async reset {out,valid,ready,busy}", {alu_out, out_valid, in_ready, busy},
        {16'h0000, 1'b0, 1'b1, 1'b0});
    chk("async reset flags", {arith_f, logic_f, cmp_f, shift_f, carry_f, div0_f}, 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    chk("no result after reset", 64'(pulses), 64'(0));
    do_op("SUB 3-6", 4'd1, 16'd3, 16'd6, 16'hFFFD, 1'b1, 1'b0, 4'b1000, 1);

    // Scenario 6
    do_op("SHL 1<<15", 4'd14, 16'd1, 16'd15, 16'h8000, 1'b0, 1'b0, 4'b0001, 1);
    do_op("SHR 8000>>20", 4'd13, 16'h8000, 16'd20, 16'h0800, 1'b0, 1'b0, 4'b0001, 1);
    do_op("GT 6,3", 4'd11, 16'd6, 16'd3, 16'd1, 1'b0, 1'b0, 4'b0010, 1);
    do_op("NOP", 4'd15, 16'd6, 16'd3, 16'd0, 1'b0, 1'b0, 4'b0000, 1);

    // Random traffic, ready ignored by the driver on purpose
    repeat (600) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      fun      = 4'($urandom_range(0, 15));
      a_i      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      case ($urandom_range(0, 4))
        0:       b_i = '0;
        1:       b_i = 16'hFFFF;
        2:       b_i = 16'($urandom_range(1, 40));
        default: b_i = 16'($urandom);
      endcase
    end
    @(negedge clk); in_valid = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
